// File: rtl/input_layer_pkg.sv
// Shared types and constants for the input_layer slice: FSM states, AXI read
// constants and line-buffer geometry.
package input_layer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_MEM,
        S_ADDR,
        S_RDATA,
        S_STREAM
    } state_t;

    localparam logic [2:0]  AXI_ARSIZE  = 3'd3;
    localparam logic [1:0]  AXI_ARBURST = 2'b01;
    localparam logic [3:0]  AXI_ARCACHE = 4'b0011;
    localparam int unsigned MAX_COLS    = 64;

    function automatic logic [3:0] beats_of(input logic [7:0] cols);
        logic [8:0] w_sum;
        w_sum = {1'b0, cols} + 9'd7;
        return w_sum[6:3];
    endfunction

    // Physical buffer holding logical row `ofs` when `base` is the oldest.
    function automatic logic [1:0] rot3(input logic [1:0] base, input logic [1:0] ofs);
        logic [2:0] w_s;
        w_s = {1'b0, base} + {1'b0, ofs};
        return (w_s >= 3'd3) ? 2'(w_s - 3'd3) : w_s[1:0];
    endfunction

endpackage

// File: rtl/input_layer_if.sv
// AXI4 master bus of input_layer: read channels used, write channels tied off.
interface input_layer_if #(
    parameter int unsigned C_S_AXI_ID_WIDTH   = 1,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_S_AXI_DATA_WIDTH = 64
);
    logic [C_S_AXI_ID_WIDTH-1:0]     M_axi_arid;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   M_axi_araddr;
    logic [7:0]                      M_axi_arlen;
    logic [2:0]                      M_axi_arsize;
    logic [1:0]                      M_axi_arburst;
    logic                            M_axi_arlock;
    logic [3:0]                      M_axi_arcache;
    logic [2:0]                      M_axi_arprot;
    logic [3:0]                      M_axi_arqos;
    logic                            M_axi_arvalid;
    logic                            M_axi_arready;
    logic [C_S_AXI_ID_WIDTH-1:0]     M_axi_rid;
    logic [C_S_AXI_DATA_WIDTH-1:0]   M_axi_rdata;
    logic [1:0]                      M_axi_rresp;
    logic                            M_axi_rlast;
    logic                            M_axi_rvalid;
    logic                            M_axi_rready;
    logic [C_S_AXI_ID_WIDTH-1:0]     M_axi_awid;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   M_axi_awaddr;
    logic [7:0]                      M_axi_awlen;
    logic [2:0]                      M_axi_awsize;
    logic [1:0]                      M_axi_awburst;
    logic                            M_axi_awlock;
    logic [3:0]                      M_axi_awcache;
    logic [2:0]                      M_axi_awprot;
    logic [3:0]                      M_axi_awqos;
    logic                            M_axi_awvalid;
    logic                            M_axi_awready;
    logic [C_S_AXI_DATA_WIDTH-1:0]   M_axi_wdata;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] M_axi_wstrb;
    logic                            M_axi_wlast;
    logic                            M_axi_wvalid;
    logic                            M_axi_wready;
    logic [C_S_AXI_ID_WIDTH-1:0]     M_axi_bid;
    logic [1:0]                      M_axi_bresp;
    logic                            M_axi_bvalid;
    logic                            M_axi_bready;

    modport master (
        output M_axi_arid, M_axi_araddr, M_axi_arlen, M_axi_arsize, M_axi_arburst,
               M_axi_arlock, M_axi_arcache, M_axi_arprot, M_axi_arqos, M_axi_arvalid,
        input  M_axi_arready,
        input  M_axi_rid, M_axi_rdata, M_axi_rresp, M_axi_rlast, M_axi_rvalid,
        output M_axi_rready,
        output M_axi_awid, M_axi_awaddr, M_axi_awlen, M_axi_awsize, M_axi_awburst,
               M_axi_awlock, M_axi_awcache, M_axi_awprot, M_axi_awqos, M_axi_awvalid,
        input  M_axi_awready,
        output M_axi_wdata, M_axi_wstrb, M_axi_wlast, M_axi_wvalid,
        input  M_axi_wready,
        input  M_axi_bid, M_axi_bresp, M_axi_bvalid,
        output M_axi_bready
    );

    modport slave (
        input  M_axi_arid, M_axi_araddr, M_axi_arlen, M_axi_arsize, M_axi_arburst,
               M_axi_arlock, M_axi_arcache, M_axi_arprot, M_axi_arqos, M_axi_arvalid,
        output M_axi_arready,
        output M_axi_rid, M_axi_rdata, M_axi_rresp, M_axi_rlast, M_axi_rvalid,
        input  M_axi_rready,
        input  M_axi_awid, M_axi_awaddr, M_axi_awlen, M_axi_awsize, M_axi_awburst,
               M_axi_awlock, M_axi_awcache, M_axi_awprot, M_axi_awqos, M_axi_awvalid,
        output M_axi_awready,
        input  M_axi_wdata, M_axi_wstrb, M_axi_wlast, M_axi_wvalid,
        output M_axi_wready,
        output M_axi_bid, M_axi_bresp, M_axi_bvalid,
        input  M_axi_bready
    );
endinterface

// File: rtl/input_layer_linebuf.sv
// Three rotating 64-byte row buffers; writes fill the oldest row, reads return
// the 3x3 window at column i_col with rows ordered oldest to newest.
module input_layer_linebuf
    import input_layer_pkg::*;
#(
    parameter int unsigned BEAT_W = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_wr_en,
    input  logic [BEAT_W-1:0] i_wr_beat,
    input  logic [63:0]       i_wr_data,
    input  logic              i_rotate,
    input  logic [5:0]        i_col,
    output logic [71:0]       o_window
);
    logic [7:0] r_mem [3][MAX_COLS];
    logic [1:0] r_wr_sel;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_sel <= '0;
        end else if (i_rotate) begin
            r_wr_sel <= rot3(r_wr_sel, 2'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int unsigned k = 0; k < 8; k++) begin
                r_mem[r_wr_sel][{i_wr_beat, 3'(k)}] <= i_wr_data[8*k +: 8];
            end
        end
    end

    // After three rotations the write select points at the oldest row (window row 0).
    always_comb begin
        o_window = '0;
        for (int unsigned r = 0; r < 3; r++) begin
            for (int unsigned c = 0; c < 3; c++) begin
                o_window[8*(3*(2-c)+r) +: 8] = r_mem[rot3(r_wr_sel, 2'(r))][i_col + 6'(c)];
            end
        end
    end
endmodule

// File: rtl/input_layer.sv
// Fetches image rows over AXI4 into three line buffers and streams 3x3 windows.
// Optional Done pulse port enabled by defining INPUT_LAYER_DONE_EN.
module input_layer
    import input_layer_pkg::*;
#(
    parameter int unsigned C_S_AXI_ID_WIDTH   = 1,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_S_AXI_DATA_WIDTH = 64,
    parameter int unsigned C_S_AXI_BURST_LEN  = 8,
    parameter int unsigned STREAM_DATA_WIDTH  = 72
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          Start,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] axi_address,
    input  logic [7:0]                    no_of_input_layers,
    input  logic [7:0]                    input_layer_row_size,
    input  logic [7:0]                    input_layer_col_size,
    input  logic                          in_layer_ddr3_data_rdy,
    output logic [STREAM_DATA_WIDTH-1:0]  input_layer_1_data,
    output logic                          input_layer_1_valid,
    input  logic                          input_layer_1_rdy,
    output logic [7:0]                    input_layer_1_id,
`ifdef INPUT_LAYER_DONE_EN
    output logic                          Done,
`endif
    input_layer_if.master                 m_axi
);
    localparam int unsigned BEAT_W = $clog2(C_S_AXI_BURST_LEN);

    state_t                        r_state, w_next;
    logic [C_S_AXI_ADDR_WIDTH-1:0] r_row_addr;
    logic [7:0]                    r_layers, r_rows, r_cols;
    logic [7:0]                    r_layer, r_fetch_row, r_win_row;
    logic [5:0]                    r_win_col;
    logic [BEAT_W-1:0]             r_beat;
    logic                          r_valid;
    logic [71:0]                   r_data;
    logic [7:0]                    r_id;
    logic                          r_done;
    logic [3:0]                    w_beats;
    logic [71:0]                   w_window;
    logic w_ar_fire, w_r_fire, w_r_done, w_out_free, w_row_end, w_load, w_row_done;
    logic w_more_rows, w_more_layers, w_unused;

    assign w_beats       = beats_of(r_cols);
    assign w_ar_fire     = (r_state == S_ADDR) && m_axi.M_axi_arready;
    assign w_r_fire      = (r_state == S_RDATA) && m_axi.M_axi_rvalid;
    assign w_r_done      = w_r_fire && m_axi.M_axi_rlast;
    assign w_out_free    = !r_valid || input_layer_1_rdy;
    assign w_row_end     = (r_state == S_STREAM) && ({2'b00, r_win_col} == r_cols - 8'd2);
    assign w_load        = (r_state == S_STREAM) && !w_row_end && w_out_free;
    assign w_row_done    = w_row_end && w_out_free;
    assign w_more_rows   = ({1'b0, r_win_row} + 9'd1) < ({1'b0, r_rows} - 9'd2);
    assign w_more_layers = ({1'b0, r_layer} + 9'd1) < {1'b0, r_layers};

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:     if (Start && no_of_input_layers != 8'd0) w_next = S_WAIT_MEM;
            S_WAIT_MEM: if (in_layer_ddr3_data_rdy) w_next = S_ADDR;
            S_ADDR:     if (m_axi.M_axi_arready) w_next = S_RDATA;
            S_RDATA:    if (w_r_done) w_next = (r_fetch_row >= 8'd2) ? S_STREAM : S_ADDR;
            S_STREAM: begin
                if (w_row_done) begin
                    if (w_more_rows)        w_next = S_ADDR;
                    else if (w_more_layers) w_next = S_WAIT_MEM;
                    else                    w_next = S_IDLE;
                end
            end
            default:    w_next = S_IDLE;
        endcase
    end

    // Rows are fetched once each in order, so the row address simply advances by
    // one stride per burst and crosses into the next layer without extra math.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_row_addr  <= '0;
            r_layers    <= '0;
            r_rows      <= '0;
            r_cols      <= '0;
            r_layer     <= '0;
            r_fetch_row <= '0;
            r_win_row   <= '0;
            r_win_col   <= '0;
            r_beat      <= '0;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_id        <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE && Start) begin
                r_row_addr  <= axi_address;
                r_layers    <= no_of_input_layers;
                r_rows      <= input_layer_row_size;
                r_cols      <= input_layer_col_size;
                r_layer     <= '0;
                r_fetch_row <= '0;
                r_win_row   <= '0;
                r_win_col   <= '0;
            end
            if (w_ar_fire) r_beat <= '0;
            if (w_r_fire)  r_beat <= r_beat + 1'b1;
            if (w_r_done) begin
                r_fetch_row <= r_fetch_row + 8'd1;
                r_row_addr  <= r_row_addr + C_S_AXI_ADDR_WIDTH'({w_beats, 3'b000});
            end
            if (w_load) begin
                r_valid   <= 1'b1;
                r_data    <= w_window;
                r_id      <= r_layer;
                r_win_col <= r_win_col + 6'd1;
            end else if (input_layer_1_rdy) begin
                r_valid <= 1'b0;
            end
            if (w_row_done) begin
                r_win_col <= '0;
                if (w_more_rows) begin
                    r_win_row <= r_win_row + 8'd1;
                end else begin
                    r_win_row   <= '0;
                    r_fetch_row <= '0;
                    if (w_more_layers) r_layer <= r_layer + 8'd1;
                    else               r_done  <= 1'b1;
                end
            end
        end
    end

    input_layer_linebuf #(.BEAT_W(BEAT_W)) u_linebuf (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_wr_en   (w_r_fire),
        .i_wr_beat (r_beat),
        .i_wr_data (m_axi.M_axi_rdata[63:0]),
        .i_rotate  (w_r_done),
        .i_col     (r_win_col),
        .o_window  (w_window)
    );

    assign input_layer_1_valid = r_valid;
    assign input_layer_1_data  = STREAM_DATA_WIDTH'(r_data);
    assign input_layer_1_id    = r_id;
`ifdef INPUT_LAYER_DONE_EN
    assign Done = r_done;
`endif

    assign m_axi.M_axi_arid    = '0;
    assign m_axi.M_axi_araddr  = r_row_addr;
    assign m_axi.M_axi_arlen   = {4'b0000, w_beats} - 8'd1;
    assign m_axi.M_axi_arsize  = AXI_ARSIZE;
    assign m_axi.M_axi_arburst = AXI_ARBURST;
    assign m_axi.M_axi_arlock  = 1'b0;
    assign m_axi.M_axi_arcache = AXI_ARCACHE;
    assign m_axi.M_axi_arprot  = '0;
    assign m_axi.M_axi_arqos   = '0;
    assign m_axi.M_axi_arvalid = (r_state == S_ADDR);
    assign m_axi.M_axi_rready  = (r_state == S_RDATA);

    assign m_axi.M_axi_awid    = '0;
    assign m_axi.M_axi_awaddr  = '0;
    assign m_axi.M_axi_awlen   = '0;
    assign m_axi.M_axi_awsize  = '0;
    assign m_axi.M_axi_awburst = '0;
    assign m_axi.M_axi_awlock  = 1'b0;
    assign m_axi.M_axi_awcache = '0;
    assign m_axi.M_axi_awprot  = '0;
    assign m_axi.M_axi_awqos   = '0;
    assign m_axi.M_axi_awvalid = 1'b0;
    assign m_axi.M_axi_wdata   = '0;
    assign m_axi.M_axi_wstrb   = '0;
    assign m_axi.M_axi_wlast   = 1'b0;
    assign m_axi.M_axi_wvalid  = 1'b0;
    assign m_axi.M_axi_bready  = 1'b1;

    assign w_unused = ^{m_axi.M_axi_rid, m_axi.M_axi_rresp, m_axi.M_axi_awready,
                        m_axi.M_axi_wready, m_axi.M_axi_bid, m_axi.M_axi_bresp,
                        m_axi.M_axi_bvalid};
endmodule

// File: tb/tb_input_layer.sv
// Directed bench for input_layer: AXI read slave backed by a byte memory and a
// window sink checked against a pixel model.
module tb_input_layer;
    localparam logic [31:0] BASE = 32'h1000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        Start;
    logic [31:0] axi_address;
    logic [7:0]  no_of_input_layers, row_size, col_size;
    logic        ddr_rdy;
    logic [71:0] data;
    logic        valid;
    logic        rdy;
    logic [7:0]  id;
`ifdef INPUT_LAYER_DONE_EN
    logic        done;
`endif

    int checks = 0;
    int fails  = 0;
    logic [7:0]  mem [4096];
    logic [31:0] q_addr [$];
    logic [7:0]  q_len  [$];

    always #5 clk = ~clk;

    input_layer_if #(.C_S_AXI_ID_WIDTH(1), .C_S_AXI_ADDR_WIDTH(32), .C_S_AXI_DATA_WIDTH(64)) axi_if ();

    input_layer #(
        .C_S_AXI_ID_WIDTH(1), .C_S_AXI_ADDR_WIDTH(32), .C_S_AXI_DATA_WIDTH(64),
        .C_S_AXI_BURST_LEN(8), .STREAM_DATA_WIDTH(72)
    ) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .Start                  (Start),
        .axi_address            (axi_address),
        .no_of_input_layers     (no_of_input_layers),
        .input_layer_row_size   (row_size),
        .input_layer_col_size   (col_size),
        .in_layer_ddr3_data_rdy (ddr_rdy),
        .input_layer_1_data     (data),
        .input_layer_1_valid    (valid),
        .input_layer_1_rdy      (rdy),
        .input_layer_1_id       (id),
`ifdef INPUT_LAYER_DONE_EN
        .Done                   (done),
`endif
        .m_axi                  (axi_if)
    );

    function automatic logic [7:0] pix(int L, int r, int c, int cols);
        return 8'((L * 97 + r * cols + c) % 256);
    endfunction

    function automatic logic [71:0] exp_win(int L, int R, int C, int cols);
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[8*(3*(2-c)+r) +: 8] = pix(L, R + r, C + c, cols);
        return w;
    endfunction

    function automatic logic [7:0] mem_rd(logic [31:0] addr);
        logic [31:0] idx;
        idx = addr - BASE;
        return (idx < 32'd4096) ? mem[idx] : 8'h00;
    endfunction

    task automatic fill_mem(input int layers, input int rows, input int cols);
        int s;
        s = ((cols + 7) / 8) * 8;
        for (int i = 0; i < 4096; i++) mem[i] = 8'hEE;
        for (int L = 0; L < layers; L++)
            for (int r = 0; r < rows; r++)
                for (int c = 0; c < cols; c++)
                    mem[L * rows * s + r * s + c] = pix(L, r, c, cols);
    endtask

    // AXI read slave: acts 2 time units after each rising edge, predicting the
    // handshakes the next edge will complete.
    bit          ar_fire, r_fire, busy;
    int          beat;
    logic [31:0] cap_addr;
    logic [7:0]  cap_len;
    initial begin
        axi_if.M_axi_arready = 1'b0; axi_if.M_axi_rvalid = 1'b0; axi_if.M_axi_rlast = 1'b0;
        axi_if.M_axi_rdata = '0; axi_if.M_axi_rid = '0; axi_if.M_axi_rresp = 2'b10;
        axi_if.M_axi_awready = 1'b0; axi_if.M_axi_wready = 1'b0; axi_if.M_axi_bid = '0;
        axi_if.M_axi_bresp = '0; axi_if.M_axi_bvalid = 1'b0;
        busy = 0; ar_fire = 0; r_fire = 0; beat = 0; cap_addr = '0; cap_len = '0;
        forever begin
            @(posedge clk); #2;
            if (!reset_n) begin
                busy = 0; ar_fire = 0; r_fire = 0;
                axi_if.M_axi_arready = 1'b0; axi_if.M_axi_rvalid = 1'b0; axi_if.M_axi_rlast = 1'b0;
                continue;
            end
            if (r_fire) begin
                axi_if.M_axi_rvalid = 1'b0;
                if (beat == int'(cap_len)) busy = 0;
                else beat++;
            end
            if (ar_fire) begin busy = 1; beat = 0; end
            axi_if.M_axi_arready = !busy && ($urandom_range(0, 2) != 0);
            if (busy && !axi_if.M_axi_rvalid) axi_if.M_axi_rvalid = ($urandom_range(0, 3) != 0);
            if (axi_if.M_axi_rvalid) begin
                for (int k = 0; k < 8; k++)
                    axi_if.M_axi_rdata[8*k +: 8] = mem_rd(cap_addr + 32'(8 * beat + k));
                axi_if.M_axi_rlast = (beat == int'(cap_len));
            end else begin
                axi_if.M_axi_rlast = 1'b0;
            end
            ar_fire = axi_if.M_axi_arvalid && axi_if.M_axi_arready;
            r_fire  = axi_if.M_axi_rvalid && axi_if.M_axi_rready;
            if (ar_fire) begin
                cap_addr = axi_if.M_axi_araddr;
                cap_len  = axi_if.M_axi_arlen;
                q_addr.push_back(cap_addr);
                q_len.push_back(cap_len);
                checks++;
                if ({axi_if.M_axi_arid, axi_if.M_axi_arsize, axi_if.M_axi_arburst, axi_if.M_axi_arlock,
                     axi_if.M_axi_arcache, axi_if.M_axi_arprot, axi_if.M_axi_arqos}
                    !== {1'b0, 3'd3, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0}) begin
                    fails++;
                    $display("FAIL ar_fields: got id=%0d size=%0d burst=%0d cache=%0d required 0/3/1/3",
                             axi_if.M_axi_arid, axi_if.M_axi_arsize, axi_if.M_axi_arburst, axi_if.M_axi_arcache);
                end
            end
        end
    end

    task automatic start_run(input int layers, input int rows, input int cols);
        @(negedge clk);
        axi_address = BASE; no_of_input_layers = 8'(layers);
        row_size = 8'(rows); col_size = 8'(cols); Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        // Scramble config so a design that fails to latch it at Start misbehaves.
        axi_address = 32'h0000_DEA0; no_of_input_layers = 8'd7; row_size = 8'd5; col_size = 8'd9;
    endtask

    task automatic run_stream(input int layers, input int rows, input int cols, input bit rand_rdy,
                              input int max_cycles, output logic [71:0] first_win);
        int L, R, C, got, total;
        bit stalled;
        logic [71:0] held;
        logic [7:0]  held_id;
        logic [71:0] e;
        L = 0; R = 0; C = 0; got = 0; stalled = 0; held = '0; held_id = '0; first_win = '0;
        total = layers * (rows - 2) * (cols - 2);
        for (int cyc = 0; cyc < max_cycles && got < total; cyc++) begin
            @(negedge clk);
            if (stalled) begin
                checks++;
                if (valid !== 1'b1 || data !== held || id !== held_id) begin
                    fails++;
                    $display("FAIL stall_hold: got valid=%0b data=%h id=%0d required 1 %h %0d",
                             valid, data, id, held, held_id);
                end
            end
            rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (valid === 1'b1 && rdy) begin
                e = exp_win(L, R, C, cols);
                if (got == 0) first_win = data;
                checks++;
                if (data !== e || id !== 8'(L)) begin
                    fails++;
                    $display("FAIL window L%0d R%0d C%0d: got %h id %0d required %h id %0d",
                             L, R, C, data, id, e, L);
                end
                got++;
                stalled = 0;
                C++;
                if (C == cols - 2) begin
                    C = 0; R++;
                    if (R == rows - 2) begin R = 0; L++; end
                end
            end else begin
                stalled = (valid === 1'b1);
                held = data; held_id = id;
            end
        end
        checks++;
        if (got != total) begin
            fails++;
            $display("FAIL window_count: got %0d required %0d", got, total);
        end
`ifdef INPUT_LAYER_DONE_EN
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin fails++; $display("FAIL done_pulse: got %b required 1", done); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin fails++; $display("FAIL done_clear: got %b required 0", done); end
`endif
        rdy = 1'b1;
        begin
            bit extra;
            extra = 0;
            repeat (20) begin
                @(negedge clk);
                if (valid !== 1'b0) extra = 1;
            end
            checks++;
            if (extra) begin fails++; $display("FAIL extra_window: got valid after last window, required none"); end
        end
    endtask

    task automatic check_addrs(input int layers, input int rows, input int cols);
        int s, n, L, r;
        logic [31:0] ea;
        s = ((cols + 7) / 8) * 8;
        n = layers * rows;
        checks++;
        if (q_addr.size() != n) begin
            fails++;
            $display("FAIL ar_count: got %0d required %0d", q_addr.size(), n);
        end
        for (int i = 0; i < q_addr.size() && i < n; i++) begin
            L = i / rows; r = i % rows;
            ea = BASE + 32'(L * rows * s + r * s);
            checks++;
            if (q_addr[i] !== ea || q_len[i] !== 8'(s / 8 - 1)) begin
                fails++;
                $display("FAIL ar_addr[%0d]: got %h len %0d required %h len %0d", i, q_addr[i], q_len[i], ea, s / 8 - 1);
            end
        end
        q_addr.delete();
        q_len.delete();
    endtask

    task automatic test_reset;
        reset_n = 1'b0; Start = 1'b0; rdy = 1'b1; ddr_rdy = 1'b1;
        axi_address = BASE; no_of_input_layers = '0; row_size = 8'd3; col_size = 8'd3;
        repeat (3) @(negedge clk);
        checks++;
        if (valid !== 1'b0 || data !== 72'h0 || id !== 8'h0) begin
            fails++; $display("FAIL reset_stream: got valid=%b data=%h id=%h required 0", valid, data, id);
        end
        checks++;
        if (axi_if.M_axi_arvalid !== 1'b0 || axi_if.M_axi_rready !== 1'b0) begin
            fails++; $display("FAIL reset_axi: got arvalid=%b rready=%b required 0 0", axi_if.M_axi_arvalid, axi_if.M_axi_rready);
        end
        checks++;
        if ({axi_if.M_axi_awvalid, axi_if.M_axi_wvalid, axi_if.M_axi_wlast, axi_if.M_axi_bready, axi_if.M_axi_awaddr}
            !== {1'b0, 1'b0, 1'b0, 1'b1, 32'h0}) begin
            fails++; $display("FAIL write_tieoff: got aw=%b w=%b wl=%b b=%b required 0 0 0 1",
                              axi_if.M_axi_awvalid, axi_if.M_axi_wvalid, axi_if.M_axi_wlast, axi_if.M_axi_bready);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero_layers;
        bit seen;
        seen = 0;
        start_run(0, 5, 5);
        repeat (50) begin
            @(negedge clk);
            if (axi_if.M_axi_arvalid !== 1'b0 || valid !== 1'b0) seen = 1;
        end
        checks++;
        if (seen) begin fails++; $display("FAIL zero_layers: got activity, required none"); end
    endtask

    task automatic test_full_stream(input bit rand_rdy);
        logic [71:0] fw;
        fill_mem(1, 49, 49);
        q_addr.delete(); q_len.delete();
        start_run(1, 49, 49);
        run_stream(1, 49, 49, rand_rdy, 20000, fw);
        checks++;
        if (fw !== 72'h62_31_00_63_32_01_64_33_02) begin
            fails++; $display("FAIL first_window: got %h required %h", fw, 72'h62_31_00_63_32_01_64_33_02);
        end
        check_addrs(1, 49, 49);
    endtask

    task automatic test_two_layers;
        logic [71:0] fw;
        fill_mem(2, 3, 3);
        q_addr.delete(); q_len.delete();
        start_run(2, 3, 3);
        run_stream(2, 3, 3, 1'b0, 500, fw);
        check_addrs(2, 3, 3);
    endtask

    task automatic test_mem_gate;
        logic [71:0] fw;
        bit seen;
        seen = 0;
        ddr_rdy = 1'b0;
        fill_mem(1, 4, 10);
        q_addr.delete(); q_len.delete();
        start_run(1, 4, 10);
        repeat (100) begin
            @(negedge clk);
            if (axi_if.M_axi_arvalid !== 1'b0) seen = 1;
        end
        checks++;
        if (seen) begin fails++; $display("FAIL mem_gate: got arvalid while not ready, required 0"); end
        ddr_rdy = 1'b1;
        run_stream(1, 4, 10, 1'b1, 2000, fw);
        check_addrs(1, 4, 10);
    endtask

    task automatic test_reset_mid;
        logic [71:0] fw;
        int n;
        fill_mem(1, 6, 30);
        rdy = 1'b1;
        start_run(1, 6, 30);
        n = 0;
        while (valid !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        while (axi_if.M_axi_rready !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        checks++;
        if (n >= 1000) begin fails++; $display("FAIL reach_rdata: got timeout, required rready"); end
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if (valid !== 1'b0 || axi_if.M_axi_arvalid !== 1'b0 || axi_if.M_axi_rready !== 1'b0 || data !== 72'h0) begin
            fails++; $display("FAIL reset_mid: got valid=%b arvalid=%b rready=%b data=%h required 0",
                              valid, axi_if.M_axi_arvalid, axi_if.M_axi_rready, data);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        q_addr.delete(); q_len.delete();
        fill_mem(1, 5, 17);
        start_run(1, 5, 17);
        run_stream(1, 5, 17, 1'b1, 3000, fw);
        check_addrs(1, 5, 17);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_zero_layers();
        test_full_stream(1'b0);
        test_full_stream(1'b1);
        test_two_layers();
        test_mem_gate();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
